// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - MIPS execute stage with iterative shift-add MULT, registered into EX/MEM
// Optional feature macro: EX_MEM_OVF_TRAP_EN (signed add/sub overflow suppresses the write-back)
module ex_mem_stage #(
    parameter int BITS_PER_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        flush,
    input  logic [1:0]  wb_ctlout,
    input  logic [2:0]  m_ctlout,
    input  logic [3:0]  ex_ctlout,
    input  logic [31:0] npcout,
    input  logic [31:0] rdata1out,
    input  logic [31:0] rdata2out,
    input  logic [31:0] s_extendout,
    input  logic [4:0]  instrout_2016,
    input  logic [4:0]  instrout_1511,
    output logic        stall,
    output logic        out_valid,
    output logic [1:0]  wb_ctl,
    output logic [2:0]  m_ctl,
    output logic [31:0] add_result,
    output logic        zero,
    output logic [31:0] alu_result,
    output logic [31:0] rdata2_q,
    output logic [4:0]  write_reg,
    output logic        ovf
);

    localparam int         MUL_ITER = 32 / BITS_PER_CYC;
    localparam logic [5:0] LAST_CNT = 6'(MUL_ITER - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] prod_q, prod_d;
    logic [1:0]  mul_wb_q, mul_wb_d;
    logic [2:0]  mul_m_q, mul_m_d;
    logic [4:0]  mul_wreg_q, mul_wreg_d;

    logic        out_valid_q, out_valid_d;
    logic [1:0]  wb_ctl_q, wb_ctl_d;
    logic [2:0]  m_ctl_q, m_ctl_d;
    logic [31:0] add_result_q, add_result_d;
    logic        zero_q, zero_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] store_data_q, store_data_d;
    logic [4:0]  write_reg_q, write_reg_d;
    logic        ovf_q, ovf_d;

    logic [31:0] op_a, op_b, sum, diff, alu_val, pp, prod_nxt, branch_tgt;
    logic [5:0]  funct;
    logic [4:0]  wreg_sel;
    logic        is_mult, bad_funct, is_add, is_sub, add_ovf, sub_ovf, ovf_hit;

    // Operand muxing, adders and overflow flags shared by all single-cycle ops
    always_comb begin
        op_a       = rdata1out;
        op_b       = ex_ctlout[0] ? s_extendout : rdata2out;
        funct      = s_extendout[5:0];
        wreg_sel   = ex_ctlout[3] ? instrout_1511 : instrout_2016;
        sum        = op_a + op_b;
        diff       = op_a - op_b;
        branch_tgt = npcout + {s_extendout[29:0], 2'b00};
        add_ovf    = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
        sub_ovf    = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
    end

    // ALUOp / funct decode
    always_comb begin
        alu_val   = 32'd0;
        is_mult   = 1'b0;
        bad_funct = 1'b0;
        is_add    = 1'b0;
        is_sub    = 1'b0;
        case (ex_ctlout[2:1])
            2'b00: begin alu_val = sum;  is_add = 1'b1; end
            2'b01: begin alu_val = diff; is_sub = 1'b1; end
            2'b11: alu_val = op_a | op_b;
            default: begin
                case (funct)
                    6'h20: begin alu_val = sum;  is_add = 1'b1; end
                    6'h22: begin alu_val = diff; is_sub = 1'b1; end
                    6'h24: alu_val = op_a & op_b;
                    6'h25: alu_val = op_a | op_b;
                    6'h2A: alu_val = {31'd0, $signed(op_a) < $signed(op_b)};
                    6'h18: is_mult = 1'b1;
                    default: bad_funct = 1'b1;
                endcase
            end
        endcase
`ifdef EX_MEM_OVF_TRAP_EN
        ovf_hit = (is_add && add_ovf) || (is_sub && sub_ovf);
`else
        ovf_hit = 1'b0;
`endif
    end

    // Partial product for the multiplier bits retired this cycle
    always_comb begin
        pp = 32'd0;
        for (int i = 0; i < BITS_PER_CYC; i++) begin
            if (mplier_q[i]) begin
                pp = pp + (mcand_q << i);
            end
        end
        prod_nxt = prod_q + pp;
    end

    // Next-state and next-output logic; flush overrides everything, including a completing MULT
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        prod_d       = prod_q;
        mul_wb_d     = mul_wb_q;
        mul_m_d      = mul_m_q;
        mul_wreg_d   = mul_wreg_q;
        out_valid_d  = out_valid_q;
        wb_ctl_d     = wb_ctl_q;
        m_ctl_d      = m_ctl_q;
        add_result_d = add_result_q;
        zero_d       = zero_q;
        alu_result_d = alu_result_q;
        store_data_d = store_data_q;
        write_reg_d  = write_reg_q;
        ovf_d        = ovf_q;
        if (flush) begin
            state_d     = IDLE;
            cnt_d       = 6'd0;
            out_valid_d = 1'b0;
            wb_ctl_d    = 2'b00;
            m_ctl_d     = 3'b000;
            ovf_d       = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && is_mult) begin
                        mcand_d     = op_a;
                        mplier_d    = op_b;
                        prod_d      = 32'd0;
                        cnt_d       = 6'd0;
                        mul_wb_d    = wb_ctlout;
                        mul_m_d     = m_ctlout;
                        mul_wreg_d  = wreg_sel;
                        state_d     = BUSY;
                        out_valid_d = 1'b0;
                        wb_ctl_d    = 2'b00;
                        m_ctl_d     = 3'b000;
                        ovf_d       = 1'b0;
                    end else if (in_valid) begin
                        out_valid_d  = 1'b1;
                        wb_ctl_d     = (bad_funct || ovf_hit) ? 2'b00 : wb_ctlout;
                        m_ctl_d      = ovf_hit ? 3'b000 : m_ctlout;
                        add_result_d = branch_tgt;
                        zero_d       = (alu_val == 32'd0);
                        alu_result_d = alu_val;
                        store_data_d = rdata2out;
                        write_reg_d  = wreg_sel;
                        ovf_d        = ovf_hit;
                    end else begin
                        out_valid_d = 1'b0;
                        wb_ctl_d    = 2'b00;
                        m_ctl_d     = 3'b000;
                        ovf_d       = 1'b0;
                    end
                end
                default: begin
                    mcand_d     = mcand_q << BITS_PER_CYC;
                    mplier_d    = mplier_q >> BITS_PER_CYC;
                    prod_d      = prod_nxt;
                    cnt_d       = cnt_q + 6'd1;
                    out_valid_d = 1'b0;
                    if (cnt_q == LAST_CNT) begin
                        state_d      = IDLE;
                        cnt_d        = 6'd0;
                        out_valid_d  = 1'b1;
                        alu_result_d = prod_nxt;
                        zero_d       = (prod_nxt == 32'd0);
                        wb_ctl_d     = mul_wb_q;
                        m_ctl_d      = mul_m_q;
                        write_reg_d  = mul_wreg_q;
                        ovf_d        = 1'b0;
                    end
                end
            endcase
        end
    end

    // State, multiplier datapath and EX/MEM output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 6'd0;
            mcand_q      <= 32'd0;
            mplier_q     <= 32'd0;
            prod_q       <= 32'd0;
            mul_wb_q     <= 2'b00;
            mul_m_q      <= 3'b000;
            mul_wreg_q   <= 5'd0;
            out_valid_q  <= 1'b0;
            wb_ctl_q     <= 2'b00;
            m_ctl_q      <= 3'b000;
            add_result_q <= 32'd0;
            zero_q       <= 1'b0;
            alu_result_q <= 32'd0;
            store_data_q <= 32'd0;
            write_reg_q  <= 5'd0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            prod_q       <= prod_d;
            mul_wb_q     <= mul_wb_d;
            mul_m_q      <= mul_m_d;
            mul_wreg_q   <= mul_wreg_d;
            out_valid_q  <= out_valid_d;
            wb_ctl_q     <= wb_ctl_d;
            m_ctl_q      <= m_ctl_d;
            add_result_q <= add_result_d;
            zero_q       <= zero_d;
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            write_reg_q  <= write_reg_d;
            ovf_q        <= ovf_d;
        end
    end

    // Stall follows the state register directly so an async reset releases it at once
    always_comb begin
        stall      = (state_q == BUSY);
        out_valid  = out_valid_q;
        wb_ctl     = wb_ctl_q;
        m_ctl      = m_ctl_q;
        add_result = add_result_q;
        zero       = zero_q;
        alu_result = alu_result_q;
        rdata2_q   = store_data_q;
        write_reg  = write_reg_q;
        ovf        = ovf_q;
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed table-driven bench for ex_mem_stage (1 and 4 bits per cycle)
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush;
    logic [1:0]  wb_ctlout;
    logic [2:0]  m_ctlout;
    logic [3:0]  ex_ctlout;
    logic [31:0] npcout, rdata1out, rdata2out, s_extendout;
    logic [4:0]  instrout_2016, instrout_1511;

    logic        stall, out_valid, zero, ovf;
    logic [1:0]  wb_ctl;
    logic [2:0]  m_ctl;
    logic [31:0] add_result, alu_result, rdata2_q;
    logic [4:0]  write_reg;

    logic        stall4, out_valid4, zero4, ovf4;
    logic [1:0]  wb_ctl4;
    logic [2:0]  m_ctl4;
    logic [31:0] add_result4, alu_result4, rdata2_q4;
    logic [4:0]  write_reg4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.BITS_PER_CYC(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout), .ex_ctlout(ex_ctlout),
        .npcout(npcout), .rdata1out(rdata1out), .rdata2out(rdata2out),
        .s_extendout(s_extendout), .instrout_2016(instrout_2016), .instrout_1511(instrout_1511),
        .stall(stall), .out_valid(out_valid), .wb_ctl(wb_ctl), .m_ctl(m_ctl),
        .add_result(add_result), .zero(zero), .alu_result(alu_result),
        .rdata2_q(rdata2_q), .write_reg(write_reg), .ovf(ovf)
    );

    ex_mem_stage #(.BITS_PER_CYC(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout), .ex_ctlout(ex_ctlout),
        .npcout(npcout), .rdata1out(rdata1out), .rdata2out(rdata2out),
        .s_extendout(s_extendout), .instrout_2016(instrout_2016), .instrout_1511(instrout_1511),
        .stall(stall4), .out_valid(out_valid4), .wb_ctl(wb_ctl4), .m_ctl(m_ctl4),
        .add_result(add_result4), .zero(zero4), .alu_result(alu_result4),
        .rdata2_q(rdata2_q4), .write_reg(write_reg4), .ovf(ovf4)
    );

    typedef struct {
        logic [3:0]  ex;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] npc, r1, r2, imm;
        logic [4:0]  rt, rd;
        logic [31:0] e_alu, e_add;
        logic        e_zero;
        logic [4:0]  e_wreg;
        logic [1:0]  e_wb;
        logic [2:0]  e_m;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] ex, input logic [1:0] wb, input logic [2:0] m,
                          input logic [31:0] npc, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] imm, input logic [4:0] rt, input logic [4:0] rd);
        ex_ctlout = ex; wb_ctlout = wb; m_ctlout = m; npcout = npc;
        rdata1out = r1; rdata2out = r2; s_extendout = imm;
        instrout_2016 = rt; instrout_1511 = rd;
    endtask

    task automatic mult_run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int f1, f4, s1, s4;
        logic [31:0] a1, a4;
        logic [4:0]  w1;
        logic [1:0]  wbv;
        f1 = 0; f4 = 0; s1 = 0; s4 = 0; a1 = 0; a4 = 0; w1 = 0; wbv = 0;
        set_op(4'b1100, 2'b10, 3'b000, 32'd0, a, b, 32'h18, 5'd1, 5'd10);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("mult_issue_out_valid", {31'd0, out_valid}, 32'd0);
        for (int k = 1; k <= 40; k++) begin
            if (stall)  s1++;
            if (stall4) s4++;
            step();
            if (out_valid && f1 == 0) begin f1 = k; a1 = alu_result; w1 = write_reg; wbv = wb_ctl; end
            if (out_valid4 && f4 == 0) begin f4 = k; a4 = alu_result4; end
        end
        chk("mult1_latency", f1, 32);
        chk("mult1_stall_cycles", s1, 32);
        chk("mult1_product", a1, exp);
        chk("mult1_write_reg", {27'd0, w1}, 32'd10);
        chk("mult1_wb_ctl", {30'd0, wbv}, 32'd2);
        chk("mult4_latency", f4, 8);
        chk("mult4_stall_cycles", s4, 8);
        chk("mult4_product", a4, exp);
    endtask

    task automatic mult_flush(input int n, input string tag);
        int seen;
        seen = 0;
        set_op(4'b1100, 2'b10, 3'b000, 32'd0, 32'd7, 32'd6, 32'h18, 5'd1, 5'd10);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (n) step();
        chk({tag, "_stall_before"}, {31'd0, stall}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk({tag, "_stall_after"}, {31'd0, stall}, 32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        for (int k = 0; k < 40; k++) begin
            step();
            if (out_valid) seen++;
        end
        chk({tag, "_no_product"}, seen, 0);
        set_op(4'b1100, 2'b10, 3'b000, 32'd0, 32'd2, 32'd3, 32'h20, 5'd1, 5'd4);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_next_add_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_next_add_alu"}, alu_result, 32'd5);
    endtask

    initial begin
        //            ex       wb     m       npc           r1            r2            imm           rt     rd      e_alu         e_add         z     wreg   e_wb   e_m
        vecs[0]  = '{4'b1100, 2'b10, 3'b000, 32'd100,      32'd15,       32'd20,       32'h20,       5'd9,  5'd3,   32'd35,       32'd228,      1'b0, 5'd3,  2'b10, 3'b000};
        vecs[1]  = '{4'b0010, 2'b00, 3'b001, 32'd5,        32'd10,       32'd10,       32'd23,       5'd4,  5'd7,   32'd0,        32'd97,       1'b1, 5'd4,  2'b00, 3'b001};
        vecs[2]  = '{4'b0001, 2'b11, 3'b010, 32'h40,       32'd1000,     32'h55,       32'hFFFFFFFC, 5'd8,  5'd0,   32'd996,      32'h30,       1'b0, 5'd8,  2'b11, 3'b010};
        vecs[3]  = '{4'b0111, 2'b10, 3'b000, 32'd0,        32'hF0F00000, 32'd0,        32'hFF,       5'd12, 5'd1,   32'hF0F000FF, 32'h3FC,      1'b0, 5'd12, 2'b10, 3'b000};
        vecs[4]  = '{4'b1100, 2'b10, 3'b000, 32'h10,       32'd5,        32'd7,        32'h22,       5'd2,  5'd31,  32'hFFFFFFFE, 32'h98,       1'b0, 5'd31, 2'b10, 3'b000};
        vecs[5]  = '{4'b1100, 2'b10, 3'b000, 32'd0,        32'hFF00FF00, 32'h0FF00FF0, 32'h24,       5'd2,  5'd5,   32'h0F000F00, 32'h90,       1'b0, 5'd5,  2'b10, 3'b000};
        vecs[6]  = '{4'b1100, 2'b10, 3'b000, 32'd0,        32'h12340000, 32'h00005678, 32'h25,       5'd2,  5'd6,   32'h12345678, 32'h94,       1'b0, 5'd6,  2'b10, 3'b000};
        vecs[7]  = '{4'b1100, 2'b10, 3'b000, 32'd0,        32'hFFFFFFFF, 32'd1,        32'h2A,       5'd2,  5'd7,   32'd1,        32'hA8,       1'b0, 5'd7,  2'b10, 3'b000};
        vecs[8]  = '{4'b1100, 2'b10, 3'b000, 32'd0,        32'd5,        32'hFFFFFFFD, 32'h2A,       5'd2,  5'd8,   32'd0,        32'hA8,       1'b1, 5'd8,  2'b10, 3'b000};
        vecs[9]  = '{4'b1100, 2'b10, 3'b100, 32'd0,        32'd3,        32'd4,        32'h26,       5'd2,  5'd9,   32'd0,        32'h98,       1'b1, 5'd9,  2'b00, 3'b100};
        vecs[10] = '{4'b0010, 2'b01, 3'b000, 32'h200,      32'd0,        32'd1,        32'd0,        5'd3,  5'd11,  32'hFFFFFFFF, 32'h200,      1'b0, 5'd3,  2'b01, 3'b000};
        vecs[11] = '{4'b0001, 2'b01, 3'b010, 32'h1000,     32'hFFFFFFFF, 32'd9,        32'd1,        5'd17, 5'd2,   32'd0,        32'h1004,     1'b1, 5'd17, 2'b01, 3'b010};

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
        set_op(4'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        repeat (2) step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_alu", alu_result, 32'd0);
        chk("rst_write_reg", {27'd0, write_reg}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        #3 rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            set_op(vecs[i].ex, vecs[i].wb, vecs[i].m, vecs[i].npc, vecs[i].r1, vecs[i].r2,
                   vecs[i].imm, vecs[i].rt, vecs[i].rd);
            in_valid = 1'b1;
            step();
            chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_stall", i), {31'd0, stall}, 32'd0);
            chk($sformatf("v%0d_alu", i), alu_result, vecs[i].e_alu);
            chk($sformatf("v%0d_add", i), add_result, vecs[i].e_add);
            chk($sformatf("v%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].e_zero});
            chk($sformatf("v%0d_write_reg", i), {27'd0, write_reg}, {27'd0, vecs[i].e_wreg});
            chk($sformatf("v%0d_wb", i), {30'd0, wb_ctl}, {30'd0, vecs[i].e_wb});
            chk($sformatf("v%0d_m", i), {29'd0, m_ctl}, {29'd0, vecs[i].e_m});
            chk($sformatf("v%0d_rdata2", i), rdata2_q, vecs[i].r2);
        end

        set_op(4'b1100, 2'b10, 3'b011, 32'd0, 32'd15, 32'd20, 32'h20, 5'd9, 5'd3);
        step();
        in_valid = 1'b0;
        step();
        chk("bubble_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bubble_wb", {30'd0, wb_ctl}, 32'd0);
        chk("bubble_m", {29'd0, m_ctl}, 32'd0);
        chk("bubble_alu_hold", alu_result, 32'd35);

        in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_flush_wb", {30'd0, wb_ctl}, 32'd0);

        set_op(4'b1100, 2'b10, 3'b000, 32'd0, 32'd3, 32'd4, 32'h18, 5'd1, 5'd10);
        step();
        chk("mult_invalid_ignored", {31'd0, stall}, 32'd0);

        mult_run(32'd7, 32'd6, 32'd42);
        mult_run(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1);
        mult_run(32'h12345678, 32'd0, 32'd0);

        mult_flush(9, "flush_c10");
        mult_flush(31, "flush_last");

        set_op(4'b1100, 2'b10, 3'b000, 32'd0, 32'd7, 32'd6, 32'h18, 5'd1, 5'd10);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("midrst_stall_pre", {31'd0, stall}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_stall4", {31'd0, stall4}, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_add", add_result, 32'd0);
        chk("midrst_rdata2", rdata2_q, 32'd0);
        chk("midrst_wb", {30'd0, wb_ctl}, 32'd0);
        #1 rst = 1'b0;
        step();

        set_op(4'b0001, 2'b10, 3'b100, 32'd0, 32'h7FFFFFFF, 32'd0, 32'd1, 5'd6, 5'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("ovf_alu", alu_result, 32'h80000000);
        chk("ovf_out_valid", {31'd0, out_valid}, 32'd1);
`ifdef EX_MEM_OVF_TRAP_EN
        chk("ovf_flag", {31'd0, ovf}, 32'd1);
        chk("ovf_wb", {30'd0, wb_ctl}, 32'd0);
        chk("ovf_m", {29'd0, m_ctl}, 32'd0);
`else
        chk("ovf_flag", {31'd0, ovf}, 32'd0);
        chk("ovf_wb", {30'd0, wb_ctl}, 32'd2);
        chk("ovf_m", {29'd0, m_ctl}, 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
